// File: rtl/data_bus_interconnect.sv
// Data-bus interconnect: decodes the core's data-port address onto one of NUM_SLV
// slaves, waits for that slave's ready strobe and returns data or an error response.
module data_bus_interconnect #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 4,
    parameter int DEC_HI  = 31,
    parameter int DEC_LO  = 20,
    parameter logic [NUM_SLV*(DEC_HI-DEC_LO+1)-1:0] SLV_BASE =
        {12'hFFF, 12'h002, 12'h001, 12'h000},
    parameter int TIMEOUT = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ready,
    output logic                      m_err,
    output logic                      m_busy,
    output logic [NUM_SLV-1:0]        s_cs,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLV-1:0]        s_ready,
    output logic [7:0]                err_cnt
);

    localparam int FW    = DEC_HI - DEC_LO + 1;
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic [NUM_SLV-1:0]  s_cs_q, s_cs_d;
    logic                s_we_q, s_we_d;
    logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
    logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
    logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
    logic                pend_err_q, pend_err_d;
    logic [CNT_W-1:0]    tmo_q, tmo_d;
    logic [7:0]          err_cnt_q, err_cnt_d;

    logic                hit;
    logic [NUM_SLV-1:0]  hit_oh;
    logic                ready_sel;
    logic [DATA_W-1:0]   rdata_sel;

    // Walk downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        hit_oh = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (m_addr[DEC_HI:DEC_LO] == SLV_BASE[i*FW +: FW]) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    // s_cs_q is one-hot, so masking with it selects the active slave's ready and data.
    always_comb begin
        ready_sel = |(s_ready & s_cs_q);
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (s_cs_q[i]) begin
                rdata_sel = rdata_sel | s_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case infers a latch.
        state_d    = state_q;
        s_cs_d     = s_cs_q;
        s_we_d     = s_we_q;
        s_addr_d   = s_addr_q;
        s_wdata_d  = s_wdata_q;
        m_rdata_d  = m_rdata_q;
        pend_err_d = pend_err_q;
        tmo_d      = tmo_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            IDLE: begin
                if (m_req) begin
                    s_addr_d  = m_addr;
                    s_wdata_d = m_wdata;
                    tmo_d     = '0;
                    if (hit) begin
                        s_cs_d     = hit_oh;
                        s_we_d     = m_we;
                        pend_err_d = 1'b0;
                        state_d    = ACCESS;
                    end else begin
                        s_cs_d     = '0;
                        s_we_d     = 1'b0;
                        pend_err_d = 1'b1;
                        if (!m_we) begin
                            m_rdata_d = ERR_DATA;
                        end
                        state_d    = RESP;
                    end
                end
            end

            ACCESS: begin
                if (ready_sel) begin
                    if (!s_we_q) begin
                        m_rdata_d = rdata_sel;
                    end
                    s_cs_d     = '0;
                    s_we_d     = 1'b0;
                    pend_err_d = 1'b0;
                    state_d    = RESP;
                end else if (tmo_q == TMO_LAST) begin
                    // Slave has been selected for TIMEOUT cycles without answering.
                    s_cs_d     = '0;
                    s_we_d     = 1'b0;
                    m_rdata_d  = ERR_DATA;
                    pend_err_d = 1'b1;
                    state_d    = RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            RESP: begin
                if (pend_err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            s_cs_q     <= '0;
            s_we_q     <= 1'b0;
            s_addr_q   <= '0;
            s_wdata_q  <= '0;
            m_rdata_q  <= '0;
            pend_err_q <= 1'b0;
            tmo_q      <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            s_cs_q     <= s_cs_d;
            s_we_q     <= s_we_d;
            s_addr_q   <= s_addr_d;
            s_wdata_q  <= s_wdata_d;
            m_rdata_q  <= m_rdata_d;
            pend_err_q <= pend_err_d;
            tmo_q      <= tmo_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign m_rdata = m_rdata_q;
    assign m_ready = (state_q == RESP);
    assign m_err   = (state_q == RESP) && pend_err_q;
    assign m_busy  = (state_q != IDLE);
    assign s_cs    = s_cs_q;
    assign s_we    = s_we_q;
    assign s_addr  = s_addr_q;
    assign s_wdata = s_wdata_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_data_bus_interconnect.sv
// Bench for data_bus_interconnect: directed and random transactions checked against
// a transaction-level model of decode, latency, response data and error counting.
module tb_data_bus_interconnect;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      m_req;
    logic                      m_we;
    logic [ADDR_W-1:0]         m_addr;
    logic [DATA_W-1:0]         m_wdata;
    logic [DATA_W-1:0]         m_rdata;
    logic                      m_ready;
    logic                      m_err;
    logic                      m_busy;
    logic [NUM_SLV-1:0]        s_cs;
    logic                      s_we;
    logic [ADDR_W-1:0]         s_addr;
    logic [DATA_W-1:0]         s_wdata;
    logic [NUM_SLV*DATA_W-1:0] s_rdata;
    logic [NUM_SLV-1:0]        s_ready;
    logic [7:0]                err_cnt;

    data_bus_interconnect dut (
        .clk     (clk),
        .reset   (reset),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .m_ready (m_ready),
        .m_err   (m_err),
        .m_busy  (m_busy),
        .s_cs    (s_cs),
        .s_we    (s_we),
        .s_addr  (s_addr),
        .s_wdata (s_wdata),
        .s_rdata (s_rdata),
        .s_ready (s_ready),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: last response data and saturating error count.
    logic [31:0] ref_rdata;
    int          ref_err_cnt;
    logic [11:0] bases [NUM_SLV] = '{12'h000, 12'h001, 12'h002, 12'hFFF};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_decode(input logic [31:0] addr);
        for (int i = 0; i < NUM_SLV; i++) begin
            if (addr[31:20] == bases[i]) return i;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; the slave answers after wait_n access cycles.
    task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int wait_n,
                          input logic [127:0] rdata_all, input logic poke, input logic noise);
        int          idx;
        int          exp_cs_cyc, exp_lat;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [3:0]  exp_oh;
        int          lat, cs_cyc;
        logic        held_ok, got_err, busy_resp;
        logic [31:0] got_rd;

        idx    = ref_decode(addr);
        exp_oh = '0;
        if (idx < 0) begin
            exp_cs_cyc = 0;
            exp_lat    = 1;
            exp_err    = 1'b1;
            exp_rd     = we ? ref_rdata : ERR_DATA;
        end else if (wait_n < TIMEOUT) begin
            exp_oh[idx] = 1'b1;
            exp_cs_cyc  = wait_n + 1;
            exp_lat     = wait_n + 2;
            exp_err     = 1'b0;
            exp_rd      = we ? ref_rdata : rdata_all[idx*32 +: 32];
        end else begin
            exp_oh[idx] = 1'b1;
            exp_cs_cyc  = TIMEOUT;
            exp_lat     = TIMEOUT + 1;
            exp_err     = 1'b1;
            exp_rd      = ERR_DATA;
        end
        ref_rdata = exp_rd;
        if (exp_err && ref_err_cnt < 255) ref_err_cnt++;

        m_req   = 1'b1;
        m_we    = we;
        m_addr  = addr;
        m_wdata = wdata;
        s_rdata = rdata_all;
        s_ready = '0;

        lat       = -1;
        cs_cyc    = 0;
        held_ok   = 1'b1;
        got_err   = 1'b0;
        got_rd    = '0;
        busy_resp = 1'b0;
        for (int t = 1; t <= 40 && lat < 0; t++) begin
            step();
            m_req = poke;
            if (poke) begin
                m_addr = $urandom;
                m_we   = ~we;
            end
            if (s_cs !== 4'b0000) begin
                cs_cyc++;
                if (s_cs !== exp_oh || s_we !== we || s_addr !== addr || s_wdata !== wdata)
                    held_ok = 1'b0;
            end
            if (m_ready === 1'b1) begin
                lat       = t;
                got_err   = m_err;
                got_rd    = m_rdata;
                busy_resp = m_busy;
            end
            s_ready = noise ? 4'($urandom) : 4'b0000;
            if (idx >= 0) s_ready[idx] = (s_cs[idx] === 1'b1) && (cs_cyc > wait_n);
        end

        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " m_err"}, 64'(got_err), 64'(exp_err));
        check({tag, " m_rdata"}, 64'(got_rd), 64'(exp_rd));
        check({tag, " cs_cycles"}, 64'(cs_cyc), 64'(exp_cs_cyc));
        check({tag, " held"}, 64'(held_ok), 64'(1));
        check({tag, " busy_resp"}, 64'(busy_resp), 64'(1));

        step();
        m_req   = 1'b0;
        s_ready = '0;
        check({tag, " ready_pulse"}, 64'(m_ready), 64'(0));
        check({tag, " idle_busy"}, 64'(m_busy), 64'(0));
        check({tag, " err_cnt"}, 64'(err_cnt), 64'(ref_err_cnt));
        step();
        check({tag, " no_requeue"}, 64'({m_busy, s_cs}), 64'(0));
    endtask

    initial begin
        logic [127:0] rd;
        logic [31:0]  a;
        int           r, w, seen_ready;

        reset   = 1'b1;
        m_req   = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        s_rdata = '0;
        s_ready = '0;
        ref_rdata   = '0;
        ref_err_cnt = 0;

        #12;
        check("rst s_cs", 64'(s_cs), 64'(0));
        check("rst s_we", 64'(s_we), 64'(0));
        check("rst s_addr", 64'(s_addr), 64'(0));
        check("rst s_wdata", 64'(s_wdata), 64'(0));
        check("rst m_rdata", 64'(m_rdata), 64'(0));
        check("rst m_ready", 64'({m_ready, m_err, m_busy}), 64'(0));
        check("rst err_cnt", 64'(err_cnt), 64'(0));
        step();
        reset = 1'b0;
        step();

        // Directed scenarios.
        rd = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'h0000_0000};
        do_txn("rd_hit_0wait", 1'b0, 32'h0010_0040, 32'h0, 0, rd, 1'b0, 1'b0);
        do_txn("wr_hit_3wait", 1'b1, 32'hFFF0_0004, 32'hA5A5_A5A5, 3, rd, 1'b0, 1'b0);
        do_txn("rd_unmapped", 1'b0, 32'h0050_0000, 32'h0, 0, rd, 1'b0, 1'b0);
        do_txn("rd_timeout", 1'b0, 32'h0000_0010, 32'h0, 1000, rd, 1'b0, 1'b0);
        do_txn("rd_last_wait", 1'b0, 32'h0020_0100, 32'h0, TIMEOUT - 1, rd, 1'b0, 1'b0);
        do_txn("wr_unmapped", 1'b1, 32'h7000_0000, 32'h5555_AAAA, 0, rd, 1'b0, 1'b0);
        do_txn("busy_poke_hit", 1'b0, 32'h0020_0008, 32'h0, 2, rd, 1'b1, 1'b0);
        do_txn("busy_poke_miss", 1'b0, 32'h0030_0000, 32'h0, 0, rd, 1'b1, 1'b0);

        // Random traffic with noise on the unselected ready bits.
        for (int n = 0; n < 40; n++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            r  = $urandom_range(0, 4);
            a  = $urandom;
            if (r < NUM_SLV) a[31:20] = bases[r];
            else             a[31:20] = 12'(12'h003 + $urandom_range(0, 200));
            w  = ($urandom_range(0, 9) == 0) ? TIMEOUT + $urandom_range(0, 3)
                                              : $urandom_range(0, 4);
            do_txn("random", 1'($urandom), a, $urandom, w, rd, 1'($urandom), 1'b1);
        end

        // Reset in the middle of an access: selection drops immediately, no response.
        m_req  = 1'b1;
        m_we   = 1'b1;
        m_addr = 32'h0000_0010;
        step();
        m_req = 1'b0;
        step();
        check("mid_access s_cs", 64'(s_cs), 64'(1));
        #2;
        reset = 1'b1;
        #1;
        check("async_rst s_cs", 64'(s_cs), 64'(0));
        check("async_rst s_we", 64'(s_we), 64'(0));
        check("async_rst busy", 64'(m_busy), 64'(0));
        check("async_rst err_cnt", 64'(err_cnt), 64'(0));
        step();
        reset = 1'b0;
        ref_err_cnt = 0;
        ref_rdata   = '0;
        seen_ready  = 0;
        for (int t = 0; t < 20; t++) begin
            step();
            if (m_ready === 1'b1 || s_cs !== 4'b0000) seen_ready++;
        end
        check("after_rst quiet", 64'(seen_ready), 64'(0));
        check("after_rst m_rdata", 64'(m_rdata), 64'(0));

        // Saturation of the error counter.
        for (int n = 0; n < 300; n++) begin
            do_txn("saturate", 1'b0, 32'h0800_0000, 32'h0, 0, rd, 1'b0, 1'b0);
        end
        check("err_cnt saturated", 64'(err_cnt), 64'(8'hFF));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
